sequenciador_separador: RTL

- Controller that sequences the 32-to-16-bit word separator in the accumulator path.
- Accepts a pair of 32-bit words through a valid/ready handshake and latches them.
- Drives the separator's two selectors so four 16-bit halves stream to the accumulator under downstream backpressure.
- Counts pairs and flags the end of each group of N_PARES pairs.

---
 rtl/sequenciador_separador.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sequenciador_separador.sv
// sequenciador_separador
//   Sequences the 32-to-16-bit word separator in the accumulator path.
//   A pair of 32-bit words is accepted through a valid/ready handshake and
//   latched. The separator selectors are then stepped so the four 16-bit
//   halves (word0 high, word0 low, word1 high, word1 low) stream downstream
//   under backpressure. Pairs are counted, and the last half of every group
//   of N_PARES pairs is tagged, followed by a one-cycle `fim` pulse.
//
// Ports
//   clock, reset                      clock, synchronous active-high reset
//   entrada_valida / entrada_pronta   upstream pair handshake
//   entrada_0, entrada_1              incoming pair (sampled on acceptance)
//   sep_entrada_0, sep_entrada_1      latched pair, to the separator
//   seletor_entrada, seletor_palavra  separator word / half selects
//   sep_saida_16                      separator combinational result
//   saida_valida / saida_pronta       downstream half-word handshake
//   saida_16                          half-word out (sep_saida_16 passthrough)
//   saida_ultima                      last half of the last pair of a group
//   fim                               one-cycle group-complete pulse
//   ocupado                           high while a pair is being emitted
module sequenciador_separador #(
  parameter int N_PARES      = 4,
  parameter int LARGURA_CONT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_valida,
  output logic        entrada_pronta,
  input  logic [31:0] entrada_0,
  input  logic [31:0] entrada_1,
  output logic [31:0] sep_entrada_0,
  output logic [31:0] sep_entrada_1,
  output logic        seletor_entrada,
  output logic        seletor_palavra,
  input  logic [15:0] sep_saida_16,
  output logic        saida_valida,
  input  logic        saida_pronta,
  output logic [15:0] saida_16,
  output logic        saida_ultima,
  output logic        fim,
  output logic        ocupado
);

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    EMITE  = 1'b1
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] C_ULTIMO = LARGURA_CONT'(N_PARES - 1);

  estado_t                 r_estado;
  logic [1:0]              r_indice;
  logic [LARGURA_CONT-1:0] r_contador;
  logic [31:0]             r_sep_0;
  logic [31:0]             r_sep_1;
  logic                    r_sel_ent;
  logic                    r_sel_pal;
  logic                    r_fim;

  logic [1:0]              w_indice_prox;
  logic                    w_sel_ent_prox;
  logic                    w_sel_pal_prox;
  logic                    w_transfere;
  logic                    w_ultimo_par;

  // Selector pair for the next half; the (1,1)/(1,0) order for word 1 is
  // the separator's own encoding, not a simple binary count.
  always_comb begin
    w_indice_prox  = r_indice + 2'd1;
    w_sel_ent_prox = 1'b0;
    w_sel_pal_prox = 1'b0;
    unique case (w_indice_prox)
      2'd0: begin w_sel_ent_prox = 1'b0; w_sel_pal_prox = 1'b0; end
      2'd1: begin w_sel_ent_prox = 1'b0; w_sel_pal_prox = 1'b1; end
      2'd2: begin w_sel_ent_prox = 1'b1; w_sel_pal_prox = 1'b1; end
      2'd3: begin w_sel_ent_prox = 1'b1; w_sel_pal_prox = 1'b0; end
    endcase
  end

  assign w_transfere  = (r_estado == EMITE) && saida_pronta;
  assign w_ultimo_par = (r_contador == C_ULTIMO);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_indice   <= '0;
      r_contador <= '0;
      r_sep_0    <= '0;
      r_sep_1    <= '0;
      r_sel_ent  <= 1'b0;
      r_sel_pal  <= 1'b0;
      r_fim      <= 1'b0;
    end else begin
      r_fim <= 1'b0;
      unique case (r_estado)
        OCIOSO: begin
          if (entrada_valida) begin
            r_sep_0   <= entrada_0;
            r_sep_1   <= entrada_1;
            r_indice  <= '0;
            r_sel_ent <= 1'b0;
            r_sel_pal <= 1'b0;
            r_estado  <= EMITE;
          end
        end
        EMITE: begin
          if (w_transfere) begin
            if (r_indice == 2'd3) begin
              r_estado <= OCIOSO;
              if (w_ultimo_par) begin
                r_contador <= '0;
                r_fim      <= 1'b1;
              end else begin
                r_contador <= r_contador + LARGURA_CONT'(1);
              end
            end else begin
              r_indice  <= w_indice_prox;
              r_sel_ent <= w_sel_ent_prox;
              r_sel_pal <= w_sel_pal_prox;
            end
          end
        end
      endcase
    end
  end

  // Ready is held low while reset is asserted and rises in the first cycle
  // after release, since the state register is already OCIOSO by then.
  assign entrada_pronta  = (r_estado == OCIOSO) && !reset;
  assign sep_entrada_0   = r_sep_0;
  assign sep_entrada_1   = r_sep_1;
  assign seletor_entrada = r_sel_ent;
  assign seletor_palavra = r_sel_pal;
  assign saida_valida    = (r_estado == EMITE);
  assign saida_16        = sep_saida_16;
  assign saida_ultima    = (r_estado == EMITE) && (r_indice == 2'd3) && w_ultimo_par;
  assign fim             = r_fim;
  assign ocupado         = (r_estado != OCIOSO);

endmodule
